// File: rtl/seg7_message_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_message_scanner_if
// Purpose  : Bundles the controller-facing write/control signals and the
//            display-pin outputs of seg7_message_scanner.
// Signals  : wr_en, wr_addr[AW], char_code[5], clear, scroll_en (controller
//            -> scanner); seg[7], an[NUM_DIGITS], frame_done (scanner ->
//            pins/controller); blink (controller -> scanner) only when
//            SEG7_MSG_BLINK_EN is defined.
// Modports : master = controller side, slave = scanner side.
// Revision : 1.0 - initial release
// ============================================================================
interface seg7_message_scanner_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MSG_LEN    = 8
);
  localparam int c_aw = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  logic                  wr_en;
  logic [c_aw-1:0]       wr_addr;
  logic [4:0]            char_code;
  logic                  clear;
  logic                  scroll_en;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_done;
`ifdef SEG7_MSG_BLINK_EN
  logic                  blink;

  modport master (
    output wr_en, wr_addr, char_code, clear, scroll_en, blink,
    input  seg, an, frame_done
  );
  modport slave (
    input  wr_en, wr_addr, char_code, clear, scroll_en, blink,
    output seg, an, frame_done
  );
`else
  modport master (
    output wr_en, wr_addr, char_code, clear, scroll_en,
    input  seg, an, frame_done
  );
  modport slave (
    input  wr_en, wr_addr, char_code, clear, scroll_en,
    output seg, an, frame_done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/seg7_message_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seg7_message_scanner
// Purpose  : Time-multiplexed 7-segment message driver. Holds a MSG_LEN
//            character buffer, scans NUM_DIGITS digit positions one per
//            REFRESH_DIV cycles and optionally scrolls the message by one
//            character every SCROLL_DIV full frames.
// Ports    : clock      - system clock, rising edge
//            reset_n    - asynchronous active-low reset
//            bus        - seg7_message_scanner_if.slave (write port, clear,
//                         scroll_en, seg/an pins, frame_done, optional blink)
// Options  : SEG7_MSG_BLINK_EN - adds the 'blink' input and a 4-bit frame
//            counter; while blink=1, seg is blanked for 8 of every 16 frames.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_message_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int MSG_LEN     = 8,
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 25
) (
  input  logic                 clock,
  input  logic                 reset_n,
  seg7_message_scanner_if.slave bus
);

  localparam int c_aw = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int c_sw = c_aw + 1;
  localparam int c_iw = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_pw = $clog2(REFRESH_DIV);
  localparam int c_fw = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [4:0]      c_blank      = 5'd20;
  localparam logic [c_pw-1:0] c_presc_last = c_pw'(REFRESH_DIV - 1);
  localparam logic [c_iw-1:0] c_idx_last   = c_iw'(NUM_DIGITS - 1);
  localparam logic [c_aw-1:0] c_off_last   = c_aw'(MSG_LEN - 1);
  localparam logic [c_fw-1:0] c_fcnt_last  = c_fw'(SCROLL_DIV - 1);
  localparam logic [c_sw-1:0] c_len_w      = c_sw'(MSG_LEN);

  logic [4:0]            r_buf [MSG_LEN];
  logic [c_pw-1:0]       r_presc;
  logic [c_iw-1:0]       r_idx;
  logic [c_aw-1:0]       r_offset;
  logic [c_fw-1:0]       r_fcnt;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_frame_done;

  logic                  w_tick;
  logic                  w_addr_ok;
  logic                  w_wr_ok;
  logic [c_sw-1:0]       w_sum;
  logic [c_aw-1:0]       w_rd_addr;
  logic [NUM_DIGITS-1:0] w_an_next;
  logic [6:0]            w_seg_next;

  // Glyph table, segment order {a,b,c,d,e,f,g}; unused codes are blank.
  function automatic logic [6:0] glyph(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'd0:    g = 7'b1111110;
      5'd1:    g = 7'b0110000;
      5'd2:    g = 7'b1101101;
      5'd3:    g = 7'b1111001;
      5'd4:    g = 7'b0110011;
      5'd5:    g = 7'b1011011;
      5'd6:    g = 7'b1011111;
      5'd7:    g = 7'b1110000;
      5'd8:    g = 7'b1111111;
      5'd9:    g = 7'b1111011;
      5'd10:   g = 7'b1110111;  // A
      5'd11:   g = 7'b1001110;  // C
      5'd12:   g = 7'b1001111;  // E
      5'd13:   g = 7'b1000111;  // F
      5'd14:   g = 7'b0110111;  // H
      5'd15:   g = 7'b0001110;  // L
      5'd16:   g = 7'b1100111;  // P
      5'd17:   g = 7'b0000101;  // r
      5'd18:   g = 7'b0011100;  // u
      5'd19:   g = 7'b0000001;  // '-'
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // Out-of-range addresses only exist when MSG_LEN is not a power of two.
  generate
    if (MSG_LEN == (1 << c_aw)) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_partial
      assign w_addr_ok = (bus.wr_addr < c_aw'(MSG_LEN));
    end
  endgenerate

  // clear takes priority, so a simultaneous write is dropped.
  assign w_wr_ok = bus.wr_en && !bus.clear && w_addr_ok;

  assign w_tick = (r_presc == c_presc_last);

  // offset < MSG_LEN and idx < NUM_DIGITS <= MSG_LEN, so a single
  // conditional subtract is enough for the modulo.
  assign w_sum     = c_sw'(r_offset) + c_sw'(r_idx);
  assign w_rd_addr = (w_sum >= c_len_w) ? c_aw'(w_sum - c_len_w) : c_aw'(w_sum);

  always_comb begin
    w_an_next        = '0;
    w_an_next[r_idx] = 1'b1;
  end

`ifdef SEG7_MSG_BLINK_EN
  logic [3:0] r_blink_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_cnt <= 4'd0;
    end else if (r_frame_done) begin
      r_blink_cnt <= r_blink_cnt + 4'd1;
    end
  end

  // The counter only moves at frame boundaries, so blanking is frame-aligned.
  assign w_seg_next = (bus.blink && r_blink_cnt[3]) ? 7'd0 : glyph(r_buf[w_rd_addr]);
`else
  assign w_seg_next = glyph(r_buf[w_rd_addr]);
`endif

  // Character buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_buf[i] <= c_blank;
      end
    end else if (bus.clear) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_buf[i] <= c_blank;
      end
    end else if (w_wr_ok) begin
      r_buf[bus.wr_addr] <= bus.char_code;
    end
  end

  // Prescaler, digit scan and registered pin outputs. The buffer read uses
  // the pre-edge contents, so a same-cycle write shows up on the next scan.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_presc      <= '0;
      r_idx        <= '0;
      r_an         <= '0;
      r_seg        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + 1'b1;
      r_frame_done <= w_tick && (r_idx == c_idx_last);
      if (w_tick) begin
        r_an  <= w_an_next;
        r_seg <= w_seg_next;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Scroll offset. Advancing on the frame_done cycle lands the new offset
  // before the next digit-0 tick, so a frame never mixes two offsets.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_offset <= '0;
      r_fcnt   <= '0;
    end else begin
      if (r_frame_done && bus.scroll_en) begin
        if (r_fcnt == c_fcnt_last) begin
          r_fcnt   <= '0;
          r_offset <= (r_offset == c_off_last) ? '0 : r_offset + 1'b1;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
      if (bus.clear) begin
        r_offset <= '0;
      end
    end
  end

  assign bus.seg        = r_seg;
  assign bus.an         = r_an;
  assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg7_message_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_message_scanner
// Purpose  : Self-checking bench for seg7_message_scanner with NUM_DIGITS=4,
//            MSG_LEN=8, REFRESH_DIV=4, SCROLL_DIV=2. Expected digit slots
//            (an/seg pairs) are queued from a reference buffer model and
//            compared as each new slot appears on the pins.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_message_scanner;

  localparam int ND = 4;
  localparam int ML = 8;
  localparam int RD = 4;
  localparam int SD = 2;

  logic clock = 1'b0;
  logic reset_n;

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q[$];
  logic [3:0]  last_an;
  int          m_buf[ML];
  int          m_off;

  seg7_message_scanner_if #(.NUM_DIGITS(ND), .MSG_LEN(ML)) bus ();

  seg7_message_scanner #(
    .NUM_DIGITS (ND),
    .MSG_LEN    (ML),
    .REFRESH_DIV(RD),
    .SCROLL_DIV (SD)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] glyph(input int c);
    case (c)
      0:  return 7'b1111110;
      1:  return 7'b0110000;
      2:  return 7'b1101101;
      3:  return 7'b1111001;
      4:  return 7'b0110011;
      5:  return 7'b1011011;
      6:  return 7'b1011111;
      7:  return 7'b1110000;
      8:  return 7'b1111111;
      9:  return 7'b1111011;
      10: return 7'b1110111;
      11: return 7'b1001110;
      12: return 7'b1001111;
      13: return 7'b1000111;
      14: return 7'b0110111;
      15: return 7'b0001110;
      16: return 7'b1100111;
      17: return 7'b0000101;
      18: return 7'b0011100;
      19: return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  // Queue the four slots of one full frame from the reference model.
  function automatic void push_frame(input bit blanked);
    logic [3:0] a;
    logic [6:0] s;
    for (int d = 0; d < ND; d++) begin
      a = 4'(1 << d);
      s = blanked ? 7'd0 : glyph(m_buf[(m_off + d) % ML]);
      exp_q.push_back({a, s});
    end
  endfunction

  // Wait (bounded) for the next digit slot: the first negedge where an moves.
  task automatic wait_slot(output logic [3:0] a, output logic [6:0] s, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (bus.an !== last_an) begin
        ok = 1'b1;
        break;
      end
    end
    a       = bus.an;
    s       = bus.seg;
    last_an = bus.an;
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.frame_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wr(input int addr, input int code);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'(addr);
    bus.char_code = 5'(code);
    m_buf[addr]   = code;
    @(negedge clock);
    bus.wr_en     = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] e;
    logic [3:0]  a;
    logic [6:0]  s;
    bit          ok;
    reset_n       = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = 3'd0;
    bus.char_code = 5'd0;
    bus.clear     = 1'b0;
    bus.scroll_en = 1'b0;
`ifdef SEG7_MSG_BLINK_EN
    bus.blink     = 1'b0;
`endif
    for (int i = 0; i < ML; i++) m_buf[i] = 20;
    m_off = 0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.seg !== 7'd0) begin
      failures++; $display("FAIL reset_seg: got %b want 0000000", bus.seg);
    end
    checks++;
    if (bus.an !== 4'd0) begin
      failures++; $display("FAIL reset_an: got %b want 0000", bus.an);
    end
    checks++;
    if (bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done);
    end
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.an !== 4'b0000) begin
      failures++; $display("FAIL pre_tick_an: got %b want 0000", bus.an);
    end
    @(negedge clock);
    checks++;
    if (bus.an !== 4'b0001 || bus.seg !== 7'd0) begin
      failures++; $display("FAIL first_tick: an/seg %b/%b want 0001/0000000", bus.an, bus.seg);
    end
    repeat (11) @(negedge clock);
    checks++;
    if (bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL fd_early: got %b want 0", bus.frame_done);
    end
    @(negedge clock);
    checks++;
    if (bus.frame_done !== 1'b1 || bus.an !== 4'b1000) begin
      failures++; $display("FAIL fd_first: fd/an %b/%b want 1/1000", bus.frame_done, bus.an);
    end
    @(negedge clock);
    checks++;
    if (bus.frame_done !== 1'b0) begin
      failures++; $display("FAIL fd_pulse_width: got %b want 0", bus.frame_done);
    end
    repeat (15) @(negedge clock);
    checks++;
    if (bus.frame_done !== 1'b1) begin
      failures++; $display("FAIL fd_period: got %b want 1 after 16 cycles", bus.frame_done);
    end
    last_an = bus.an;
    push_frame(1'b0);
    push_frame(1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_slot(a, s, ok);
      checks++;
      if (!ok || {a, s} !== e) begin
        failures++;
        $display("FAIL reset_scan: an/seg %b/%b want %b/%b ok=%0d", a, s, e[10:7], e[6:0], ok);
      end
    end
  endtask

  task automatic test_static();
    logic [10:0] e;
    logic [3:0]  a;
    logic [6:0]  s;
    bit          ok;
    wr(0, 11); wr(1, 12); wr(2, 0); wr(3, 1);
    wait_fd(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL static_fd: frame_done got 0 want 1 within 40 cycles");
    end
    last_an = bus.an;
    repeat (10) push_frame(1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_slot(a, s, ok);
      checks++;
      if (!ok || {a, s} !== e) begin
        failures++;
        $display("FAIL static_scan: an/seg %b/%b want %b/%b ok=%0d", a, s, e[10:7], e[6:0], ok);
      end
    end
  endtask

  task automatic test_scroll();
    logic [10:0] e;
    logic [3:0]  a;
    logic [6:0]  s;
    bit          ok;
    // Step off the current frame_done cycle so it is not counted.
    @(negedge clock);
    bus.scroll_en = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      m_off = (k / SD) % ML;
      push_frame(1'b0);
    end
    m_off = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_slot(a, s, ok);
      checks++;
      if (!ok || {a, s} !== e) begin
        failures++;
        $display("FAIL scroll_scan: an/seg %b/%b want %b/%b ok=%0d", a, s, e[10:7], e[6:0], ok);
      end
    end
    // Frame 16's pulse is still in flight; disabling now keeps it uncounted.
    bus.scroll_en = 1'b0;
  endtask

  task automatic test_write_tick();
    logic [3:0] a;
    logic [6:0] s;
    bit         ok;
    bit         found;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_slot(a, s, ok);
      if (ok && a == 4'b0010) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL wt_find: an got %b want 0010 within 8 slots", a);
    end
    repeat (3) @(negedge clock);
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'd2;
    bus.char_code = 5'd14;
    @(negedge clock);
    bus.wr_en = 1'b0;
    checks++;
    if (bus.an !== 4'b0100 || bus.seg !== glyph(m_buf[2])) begin
      failures++;
      $display("FAIL wt_old_glyph: an/seg %b/%b want 0100/%b", bus.an, bus.seg, glyph(m_buf[2]));
    end
    m_buf[2] = 14;
    repeat (16) @(negedge clock);
    checks++;
    if (bus.an !== 4'b0100 || bus.seg !== 7'b0110111) begin
      failures++; $display("FAIL wt_new_glyph: an/seg %b/%b want 0100/0110111", bus.an, bus.seg);
    end
    last_an = bus.an;
  endtask

  task automatic test_clear();
    logic [10:0] e;
    logic [3:0]  a;
    logic [6:0]  s;
    bit          ok;
    bit          found;
    // Scroll exactly one step so that clear has a non-zero offset to reset.
    wait_fd(ok);
    @(negedge clock);
    bus.scroll_en = 1'b1;
    wait_fd(ok);
    wait_fd(ok);
    @(negedge clock);
    bus.scroll_en = 1'b0;
    m_off = 1;
    wait_fd(ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL clr_fd: frame_done got 0 want 1 within 40 cycles");
    end
    last_an = bus.an;
    push_frame(1'b0);
    found = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_slot(a, s, ok);
      checks++;
      if (!ok || {a, s} !== e) begin
        failures++;
        $display("FAIL clr_offset1: an/seg %b/%b want %b/%b ok=%0d", a, s, e[10:7], e[6:0], ok);
      end
    end
    for (int i = 0; i < 8; i++) begin
      wait_slot(a, s, ok);
      if (ok && a == 4'b0010) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL clr_find: an got %b want 0010 within 8 slots", a);
    end
    bus.clear     = 1'b1;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 3'd1;
    bus.char_code = 5'd10;
    @(negedge clock);
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    for (int i = 0; i < ML; i++) m_buf[i] = 20;
    m_off = 0;
    // Scan continues from digit 2; everything now reads blank.
    for (int k = 0; k < 6; k++) exp_q.push_back({4'(1 << ((k + 2) % ND)), 7'd0});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_slot(a, s, ok);
      checks++;
      if (!ok || {a, s} !== e) begin
        failures++;
        $display("FAIL clr_blank: an/seg %b/%b want %b/%b ok=%0d", a, s, e[10:7], e[6:0], ok);
      end
    end
    wr(0, 11); wr(1, 12); wr(2, 0); wr(3, 1);
    wait_fd(ok);
    last_an = bus.an;
    push_frame(1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_slot(a, s, ok);
      checks++;
      if (!ok || {a, s} !== e) begin
        failures++;
        $display("FAIL clr_offset0: an/seg %b/%b want %b/%b ok=%0d", a, s, e[10:7], e[6:0], ok);
      end
    end
  endtask

  task automatic test_glyphs();
    logic [10:0] e;
    logic [3:0]  a;
    logic [6:0]  s;
    bit          ok;
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 4; j++) wr(j, 4 * b + j);
      wait_fd(ok);
      last_an = bus.an;
      push_frame(1'b0);
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        wait_slot(a, s, ok);
        checks++;
        if (!ok || {a, s} !== e) begin
          failures++;
          $display("FAIL glyph_codes_%0d: an/seg %b/%b want %b/%b ok=%0d",
                   4 * b, a, s, e[10:7], e[6:0], ok);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] e;
    logic [3:0]  a;
    logic [6:0]  s;
    bit          ok;
    bit          blanked;
    for (int j = 0; j < 4; j++) wr(j, 8);
    wait_fd(ok);
    wait_fd(ok);
    checks++;
    if (bus.seg !== 7'b1111111) begin
      failures++; $display("FAIL ar_pre: seg got %b want 1111111", bus.seg);
    end
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.seg !== 7'd0 || bus.an !== 4'd0 || bus.frame_done !== 1'b0) begin
      failures++;
      $display("FAIL ar_outputs: seg/an/fd %b/%b/%b want 0000000/0000/0", bus.seg, bus.an, bus.frame_done);
    end
    @(negedge clock);
    for (int i = 0; i < ML; i++) m_buf[i] = 20;
    m_off   = 0;
    last_an = 4'd0;
    reset_n = 1'b1;
`ifdef SEG7_MSG_BLINK_EN
    bus.blink = 1'b1;
`endif
    // Only addr 0/1 rewritten: addr 2/3 must read blank after reset.
    wr(0, 11);
    wr(1, 12);
`ifdef SEG7_MSG_BLINK_EN
    for (int k = 0; k <= 16; k++) begin
      blanked = (k >= 8) && (k < 16);
      push_frame(blanked);
    end
`else
    blanked = 1'b0;
    push_frame(blanked);
    push_frame(blanked);
`endif
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      wait_slot(a, s, ok);
      checks++;
      if (!ok || {a, s} !== e) begin
        failures++;
        $display("FAIL ar_rescan: an/seg %b/%b want %b/%b ok=%0d", a, s, e[10:7], e[6:0], ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_scroll();
    test_write_tick();
    test_clear();
    test_glyphs();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
